// File: rtl/laser_host.sv
// laser_host: drives the LASER point stream, waits for DONE, then scores the returned centres.
// Latency: START to RES_VALID = 2 + 40 + RUN cycles + 1 + 40 + 1 cycles.
// Backpressure: none; START and loads are ignored while BUSY. Macro LASER_HOST_DONE_WAIT_EN lets DONE stall the stream at point 0.
module laser_host #(
   parameter int NUM_PT    = 40,
   parameter int R2        = 16,
   parameter int MAX_CYCLE = 50000,
   parameter int CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             LD_EN,
   input  logic [5:0]       LD_ADDR,
   input  logic [3:0]       LD_X,
   input  logic [3:0]       LD_Y,
   input  logic             START,
   output logic             BUSY,
   output logic             DUT_RST,
   output logic [3:0]       DUT_X,
   output logic [3:0]       DUT_Y,
   input  logic [3:0]       DUT_C1X,
   input  logic [3:0]       DUT_C1Y,
   input  logic [3:0]       DUT_C2X,
   input  logic [3:0]       DUT_C2Y,
   input  logic             DUT_DONE,
   output logic             RES_VALID,
   output logic [5:0]       RES_COVER,
   output logic [CNT_W-1:0] RES_CYCLES,
   output logic             RES_TIMEOUT,
   output logic             RES_PROTO_ERR
);

   typedef enum logic [2:0] {S_IDLE, S_DRST, S_SEND, S_RUN, S_SCORE, S_REPORT} state_t;

   localparam logic [5:0] LAST_IDX = 6'(NUM_PT - 1);

   state_t           state, state_n;
   logic [3:0]       mem_x [NUM_PT];
   logic [3:0]       mem_y [NUM_PT];
   logic [5:0]       idx;
   logic [CNT_W-1:0] run_cnt;
   logic [5:0]       cover_cnt;
   logic             tmo_flag, perr_flag, dut_rst;
   logic [3:0]       c1x, c1y, c2x, c2y;
   logic             start_ok, advance, latch_c, time_up, proto_set;
   logic [3:0]       px, py;
   logic [8:0]       d1, d2;
   logic             hit;
`ifdef LASER_HOST_DONE_WAIT_EN
   logic [3:0]       stall_cnt;
`endif

   // Squared distance; |a-b| squared equals the signed 5-bit difference squared.
   function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                        input logic [3:0] bx, input logic [3:0] by);
      logic [3:0] adx, ady;
      adx = (ax >= bx) ? ax - bx : bx - ax;
      ady = (ay >= by) ? ay - by : by - ay;
      return 9'(adx) * 9'(adx) + 9'(ady) * 9'(ady);
   endfunction

   assign start_ok = (state == S_IDLE) && START;
   assign px       = mem_x[idx];
   assign py       = mem_y[idx];
   assign d1       = dist2(c1x, c1y, px, py);
   assign d2       = dist2(c2x, c2y, px, py);
   // An unknown centre yields an unknown compare, which the if() below treats as not covered.
   assign hit      = (32'(d1) <= R2) || (32'(d2) <= R2);

   // Point memory: written only while idle, never reset so the image survives RST_N.
   always_ff @(posedge CLK) begin
      if (LD_EN && (state == S_IDLE) && (32'(LD_ADDR) < NUM_PT)) begin
         mem_x[LD_ADDR] <= LD_X;
         mem_y[LD_ADDR] <= LD_Y;
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state logic plus the single-cycle event strobes used by the datapath.
   always_comb begin
      state_n   = state;
      advance   = 1'b0;
      latch_c   = 1'b0;
      time_up   = 1'b0;
      proto_set = 1'b0;
      case (state)
         S_IDLE: if (START) state_n = S_DRST;
         S_DRST: begin
            advance = 1'b1;
            if (idx == 6'd1) state_n = S_SEND;
         end
         S_SEND: begin
            if (DUT_DONE) begin
`ifdef LASER_HOST_DONE_WAIT_EN
               // Early DONE at point 0 holds the stream for up to 11 cycles.
               if (!((idx == 6'd0) && (stall_cnt != 4'd11))) begin
                  proto_set = 1'b1;
                  state_n   = S_REPORT;
               end
`else
               proto_set = 1'b1;
               state_n   = S_REPORT;
`endif
            end else begin
               advance = 1'b1;
               if (idx == LAST_IDX) state_n = S_RUN;
            end
         end
         S_RUN: begin
            if (DUT_DONE) begin
               latch_c = 1'b1;
               state_n = S_SCORE;
            end else if (32'(run_cnt) >= MAX_CYCLE) begin
               latch_c = 1'b1;
               time_up = 1'b1;
               state_n = S_SCORE;
            end
         end
         S_SCORE: begin
            advance = 1'b1;
            if (idx == LAST_IDX) state_n = S_REPORT;
         end
         S_REPORT: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // Index, counters, result flags and latched centres.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idx       <= '0;
         dut_rst   <= 1'b1;
         run_cnt   <= '0;
         cover_cnt <= '0;
         tmo_flag  <= 1'b0;
         perr_flag <= 1'b0;
         c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
      end else begin
         idx     <= (state_n != state) ? 6'd0 : (advance ? idx + 6'd1 : idx);
         dut_rst <= (state_n == S_DRST);
         if (start_ok) begin
            run_cnt   <= '0;
            cover_cnt <= '0;
            tmo_flag  <= 1'b0;
            perr_flag <= 1'b0;
         end else begin
            if ((state == S_RUN) && !DUT_DONE && (run_cnt != '1)) run_cnt <= run_cnt + CNT_W'(1);
            if ((state == S_SCORE) && hit) cover_cnt <= cover_cnt + 6'd1;
            if (time_up)   tmo_flag  <= 1'b1;
            if (proto_set) perr_flag <= 1'b1;
         end
         if (latch_c) begin
            c1x <= DUT_C1X; c1y <= DUT_C1Y;
            c2x <= DUT_C2X; c2y <= DUT_C2Y;
         end
      end
   end

`ifdef LASER_HOST_DONE_WAIT_EN
   // Counts consecutive DONE-high stall cycles while the stream waits at point 0.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                             stall_cnt <= '0;
      else if ((state == S_SEND) && DUT_DONE) stall_cnt <= stall_cnt + 4'd1;
      else                                    stall_cnt <= '0;
   end
`endif

   assign BUSY          = (state != S_IDLE);
   assign DUT_RST       = dut_rst;
   assign DUT_X         = (state == S_SEND) ? px : 4'd0;
   assign DUT_Y         = (state == S_SEND) ? py : 4'd0;
   assign RES_VALID     = (state == S_REPORT);
   assign RES_COVER     = cover_cnt;
   assign RES_CYCLES    = run_cnt;
   assign RES_TIMEOUT   = tmo_flag;
   assign RES_PROTO_ERR = perr_flag;

endmodule

// File: tb/tb_laser_host.sv
// tb_laser_host: randomized LASER stub with a scoreboard for the streamed points and result pulses.
// Expected results come from a geometric model of the loaded image and the stub's scenario.
module tb_laser_host;
   localparam int NPT  = 40;
   localparam int MAXC = 100;
   localparam int M_DONE = 0, M_PROTO = 1, M_TMO = 2, M_STALL = 3, M_ABORT = 4;

   logic        CLK = 1'b0, RST_N = 1'b1, LD_EN = 1'b0, START = 1'b0, DUT_DONE = 1'b0;
   logic [5:0]  LD_ADDR = '0;
   logic [3:0]  LD_X = '0, LD_Y = '0;
   logic [3:0]  DUT_C1X = '0, DUT_C1Y = '0, DUT_C2X = '0, DUT_C2Y = '0;
   logic        BUSY, DUT_RST, RES_VALID, RES_TIMEOUT, RES_PROTO_ERR;
   logic [3:0]  DUT_X, DUT_Y;
   logic [5:0]  RES_COVER;
   logic [15:0] RES_CYCLES;

   laser_host #(.MAX_CYCLE(MAXC)) dut (
      .CLK(CLK), .RST_N(RST_N), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_X(LD_X), .LD_Y(LD_Y),
      .START(START), .BUSY(BUSY), .DUT_RST(DUT_RST), .DUT_X(DUT_X), .DUT_Y(DUT_Y),
      .DUT_C1X(DUT_C1X), .DUT_C1Y(DUT_C1Y), .DUT_C2X(DUT_C2X), .DUT_C2Y(DUT_C2Y),
      .DUT_DONE(DUT_DONE), .RES_VALID(RES_VALID), .RES_COVER(RES_COVER), .RES_CYCLES(RES_CYCLES),
      .RES_TIMEOUT(RES_TIMEOUT), .RES_PROTO_ERR(RES_PROTO_ERR));

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [5:0]  cov;
      logic [15:0] cyc;
      logic        tmo;
      logic        perr;
   } res_t;

   int         n_vec = 0, n_err = 0;
   res_t       exp_res[$];
   logic [7:0] exp_pt[$];
   int         exp_len[$];
   logic [3:0] mx [NPT];
   logic [3:0] my [NPT];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic miss(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic int sqd(int ax, int ay, int bx, int by);
      return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
   endfunction

   function automatic int model_cover(int ax, int ay, int bx, int by);
      int n = 0;
      for (int i = 0; i < NPT; i++)
         if (sqd(ax, ay, mx[i], my[i]) <= 16 || sqd(bx, by, mx[i], my[i]) <= 16) n++;
      return n;
   endfunction

   task automatic set_c(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      DUT_C1X = a; DUT_C1Y = b; DUT_C2X = c; DUT_C2Y = d;
   endtask

   task automatic rand_c();
      set_c(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic load_all();
      for (int i = 0; i < NPT; i++) begin
         @(negedge CLK);
         LD_EN = 1'b1; LD_ADDR = 6'(i); LD_X = mx[i]; LD_Y = my[i];
      end
      @(negedge CLK);
      LD_ADDR = 6'($urandom_range(NPT, 63)); LD_X = 4'($urandom); LD_Y = 4'($urandom);
      @(negedge CLK);
      LD_EN = 1'b0;
   endtask

   // Monitor: DUT_RST width, streamed points, idle stream value and result pulses.
   int         mon_rst_len = 0, mon_left = 0;
   logic [7:0] mon_p;
   res_t       mon_r;
   always @(negedge CLK) begin
      if (!RST_N) begin
         mon_rst_len = 0;
         mon_left    = 0;
      end else begin
         if (BUSY && DUT_RST) mon_rst_len++;
         else if (mon_rst_len > 0) begin
            chk("dut_rst_len", 32'(mon_rst_len), 32'd2);
            mon_rst_len = 0;
            if (exp_len.size() > 0) mon_left = exp_len.pop_front();
            else miss("unexpected_stream");
         end
         if (mon_left > 0) begin
            mon_p = exp_pt.pop_front();
            chk("dut_x", 32'(DUT_X), 32'(mon_p[7:4]));
            chk("dut_y", 32'(DUT_Y), 32'(mon_p[3:0]));
            mon_left--;
         end else begin
            chk("dut_xy_quiet", 32'({DUT_X, DUT_Y}), 32'd0);
         end
         if (RES_VALID) begin
            if (exp_res.size() == 0) miss("unexpected_res_valid");
            else begin
               mon_r = exp_res.pop_front();
               chk("res_cover",   32'(RES_COVER),     32'(mon_r.cov));
               chk("res_cycles",  32'(RES_CYCLES),    32'(mon_r.cyc));
               chk("res_timeout", 32'(RES_TIMEOUT),   32'(mon_r.tmo));
               chk("res_proto",   32'(RES_PROTO_ERR), 32'(mon_r.perr));
            end
         end
      end
   end

   // One run: queue the expected stream/result, then play the LASER stub for the scenario.
   task automatic run(input int mode, input int k, input logic [3:0] ax, input logic [3:0] ay,
                      input logic [3:0] bx, input logic [3:0] by);
      res_t r;
      int   send_n, run_k, w, n_pts;
      bit   proto, has_run;
      proto   = (mode == M_PROTO);
      has_run = (mode != M_PROTO);
      run_k   = (mode == M_STALL) ? 5 : k;
      send_n  = (mode == M_PROTO) ? k + 1 : NPT;
      if (mode == M_STALL) begin
`ifdef LASER_HOST_DONE_WAIT_EN
         send_n = NPT + k;
         for (int i = 0; i < k; i++) exp_pt.push_back({mx[0], my[0]});
`else
         send_n  = 1;
         proto   = 1'b1;
         has_run = 1'b0;
`endif
      end
      n_pts = proto ? send_n : NPT;
      for (int i = 0; i < n_pts; i++) exp_pt.push_back({mx[i], my[i]});
      exp_len.push_back(send_n);
      if (proto)              r = '{cov: 6'd0, cyc: 16'd0, tmo: 1'b0, perr: 1'b1};
      else if (mode == M_TMO) r = '{cov: 6'(model_cover(ax, ay, bx, by)), cyc: 16'(MAXC + 1), tmo: 1'b1, perr: 1'b0};
      else                    r = '{cov: 6'(model_cover(ax, ay, bx, by)), cyc: 16'(run_k), tmo: 1'b0, perr: 1'b0};
      if (mode != M_ABORT) exp_res.push_back(r);

      if (mode == M_TMO) set_c(ax, ay, bx, by);
      else rand_c();
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      w = 0;
      while (DUT_RST && w < 10) begin @(negedge CLK); w++; end
      if (w >= 10) begin miss("dut_rst_stuck"); return; end
      for (int s = 0; s < send_n; s++) begin
         DUT_DONE = (mode == M_PROTO && s == k) || (mode == M_STALL && s < k);
         START    = (s == 2);
         LD_EN    = (s == 3);
         LD_ADDR  = 6'($urandom_range(0, NPT - 1));
         LD_X     = 4'($urandom);
         LD_Y     = 4'($urandom);
         @(negedge CLK);
      end
      DUT_DONE = 1'b0; START = 1'b0; LD_EN = 1'b0;
      if (has_run && mode != M_TMO) begin
         repeat (run_k) @(negedge CLK);
         DUT_DONE = 1'b1;
         set_c(ax, ay, bx, by);
         @(negedge CLK);
         DUT_DONE = 1'b0;
         rand_c();
      end
      if (mode == M_ABORT) begin
         repeat (10) @(negedge CLK);
         RST_N = 1'b0;
         #1;
         chk("abort_busy", 32'(BUSY), 32'd0);
         chk("abort_dut_rst", 32'(DUT_RST), 32'd1);
         chk("abort_res_valid", 32'(RES_VALID), 32'd0);
         @(negedge CLK); RST_N = 1'b1;
         @(negedge CLK);
         chk("post_abort_dut_rst", 32'(DUT_RST), 32'd0);
      end else begin
         w = 0;
         while (!RES_VALID && w < 400) begin @(negedge CLK); w++; end
         if (w >= 400) miss("res_valid_timeout");
         else begin
            repeat (3) @(negedge CLK);
            chk("hold_cover", 32'(RES_COVER), 32'(r.cov));
            chk("hold_cycles", 32'(RES_CYCLES), 32'(r.cyc));
            chk("idle_busy", 32'(BUSY), 32'd0);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_dut_rst", 32'(DUT_RST), 32'd1);
      chk("rst_res_valid", 32'(RES_VALID), 32'd0);
      chk("rst_cover", 32'(RES_COVER), 32'd0);
      chk("rst_cycles", 32'(RES_CYCLES), 32'd0);
      chk("rst_flags", 32'({RES_TIMEOUT, RES_PROTO_ERR}), 32'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      for (int i = 0; i < NPT; i++) begin mx[i] = 4'd5; my[i] = 4'd5; end
      load_all();
      run(M_DONE, 10, 4'd5, 4'd5, 4'd0, 4'd0);

      for (int i = 0; i < NPT; i++) begin
         mx[i] = (i < 16) ? 4'd0 : 4'd15;
         my[i] = (i < 16) ? 4'(i) : 4'd15;
      end
      load_all();
      run(M_DONE, 3, 4'd0, 4'd4, 4'd15, 4'd15);

      for (int i = 0; i < NPT; i++) begin mx[i] = 4'($urandom); my[i] = 4'($urandom); end
      load_all();
      run(M_PROTO, 17, 4'd7, 4'd7, 4'd3, 4'd3);
      run(M_TMO, 0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      run(M_STALL, 3, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      run(M_ABORT, 4, 4'd8, 4'd8, 4'd2, 4'd12);
      run(M_DONE, 6, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));

      for (int t = 0; t < 6; t++) begin
         if (t % 2 == 0) begin
            for (int i = 0; i < NPT; i++) begin mx[i] = 4'($urandom); my[i] = 4'($urandom); end
            load_all();
         end
         run(M_DONE, int'($urandom_range(0, 20)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end

      repeat (5) @(negedge CLK);
      chk("res_queue_left", 32'(exp_res.size()), 32'd0);
      chk("pt_queue_left", 32'(exp_pt.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
